pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register, successor to the fixed MEM/WB flop. Carries an opaque payload bundle (we, waddr, wdata, whilo, hi, lo, LLbit, ...) between any two stages. Uses a valid/ready handshake in place of a global stall vector, with an optional 2-entry skid buffer that makes up_ready a pure register output. Adds a synchronous flush and saturating stall/bubble performance counters.

Parameters:
DATA_W, 32, payload width in bits (1..1024).
SKID, 1, 0 = single register with combinational up_ready; 1 = main register plus skid register, up_ready registered.
CNT_W, 16, width of each performance counter (2..32).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  discard all held entries (exception/branch squash).
up_valid  in  1  upstream entry present.
up_ready  out  1  stage can accept; transfer when up_valid & up_ready at posedge.
up_data  in  DATA_W  upstream payload.
dn_valid  out  1  downstream entry present.
dn_ready  in  1  downstream accepts; transfer when dn_valid & dn_ready at posedge.
dn_data  out  DATA_W  payload; all-zero whenever dn_valid=0 (NOP bubble).
occupancy  out  2  entries held, 0..1 when SKID=0, 0..2 when SKID=1.
cnt_clr  in  1  synchronous clear of both counters.
stall_cnt  out  CNT_W  cycles with dn_valid=1 & dn_ready=0.
bubble_cnt  out  CNT_W  cycles with dn_valid=0 & dn_ready=1.

Behaviour:
- Reset (rst=1 at posedge): dn_valid=0, dn_data=0, skid empty, occupancy=0, counters=0. up_ready=1 in the cycle after reset. rst has priority over every other input.
- Priority per edge: rst > flush > normal operation.
- dn_data invariant: zero-filled whenever dn_valid=0. Bubbles never expose stale payload.
- SKID=0:
  - up_ready = ~dn_valid | dn_ready (combinational).
  - At posedge with up_ready=1: dn_valid<=up_valid; dn_data<=up_valid ? up_data : 0.
  - With up_ready=0: hold dn_valid and dn_data.
  - Latency 1 cycle. Full throughput.
- SKID=1:
  - up_ready = ~skid_valid (register output, no combinational path from dn_ready).
  - Main register empty, or drained this cycle, with skid empty: an accepted input enters main.
  - dn_valid=1, dn_ready=0, input accepted: input enters skid, up_ready drops next cycle.
  - dn_ready=1 with skid full: skid moves to main, skid empties. A new input cannot be accepted that cycle because up_ready=0.
  - Latency 1 cycle, full throughput. Order is strictly preserved.
- occupancy = dn_valid + skid_valid.
- flush=1 at posedge:
  - Main and skid cleared, dn_valid=0, dn_data=0.
  - An upstream transfer in the same cycle is dropped, even though up_ready was 1.
  - A downstream transfer in that cycle still completes (the entry was consumed). up_ready=1 next cycle.
- Counters:
  - Evaluated on pre-edge dn_valid/dn_ready.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clr beats increment: a clear cycle yields 0.
  - Counting continues during flush cycles. Counters are not affected by flush.
- Simultaneous up transfer and dn transfer with occupancy=1: main takes new data, occupancy stays 1.
- Mid-operation reset discards held entries without completing a transfer.

Test Plan:
- Reset: hold rst 2 cycles with up_valid=1, up_data=0xDEADBEEF -> dn_valid=0, dn_data=0, occupancy=0, counters=0; the first post-reset edge with up_valid=1 gives dn_data=0xDEADBEEF.
- Streaming (SKID=1, dn_ready=1): send 0x1,0x2,0x3 back-to-back -> dn_data shows 0x1,0x2,0x3 on consecutive cycles, 1-cycle latency, up_ready stays 1.
- Backpressure (SKID=1): dn_ready=0 while sending 0xA then 0xB -> occupancy reaches 2, up_ready=0, stall_cnt increments per cycle. Raise dn_ready -> outputs 0xA then 0xB, no loss or duplication.
- Bubble: up_valid=0 for 3 cycles with dn_ready=1 -> dn_valid=0, dn_data=0, bubble_cnt=3.
- Flush: occupancy=2 (0xA, 0xB) and up_valid=1 with 0xC, pulse flush -> next cycle dn_valid=0, occupancy=0, dn_data=0. 0xC is never emitted.
- Saturation (CNT_W=2): hold a stall 6 cycles -> stall_cnt=3. Pulse cnt_clr while stalled -> stall_cnt=0 that cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and saturating stall/bubble counters.
// Empty slots always hold an all-zero payload so bubbles read as NOPs.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;

    assign dn_valid  = main_valid;
    assign dn_data   = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_data;

            // Registered ready: only the skid occupancy gates acceptance.
            assign up_ready   = ~skid_valid;

            // Main/skid update. With skid full, ready is low, so the only
            // move is skid -> main when downstream drains. Otherwise main
            // refills when it is empty or draining, and a stalled main
            // diverts the accepted input into skid.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                end else if (skid_valid) begin
                    if (dn_ready) begin
                        main_valid <= 1'b1;
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        skid_data  <= '0;
                    end
                end else if (!main_valid || dn_ready) begin
                    main_valid <= up_valid;
                    main_data  <= up_valid ? up_data : '0;
                end else if (up_valid) begin
                    skid_valid <= 1'b1;
                    skid_data  <= up_data;
                end
            end
        end else begin : g_noskid
            assign skid_valid = 1'b0;

            // Combinational ready: accept when empty or draining this cycle.
            assign up_ready   = ~main_valid | dn_ready;

            // Single register: load (or load a bubble) whenever ready, else hold.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                end else if (up_ready) begin
                    main_valid <= up_valid;
                    main_data  <= up_valid ? up_data : '0;
                end
            end
        end
    endgenerate

    // Stall counter: downstream holding off a valid entry; saturates, clear wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
        end else if (main_valid && !dn_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Bubble counter: downstream ready with nothing to take; saturates, clear wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            bubble_cnt <= '0;
        end else if (!main_valid && dn_ready && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a SKID=1 instance, a
// SKID=1 instance with 2-bit counters sharing its stimulus, and a SKID=0
// instance with its own stimulus.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        up_valid;
    logic        up_ready;
    logic [31:0] up_data;
    logic        dn_valid;
    logic        dn_ready;
    logic [31:0] dn_data;
    logic [1:0]  occupancy;
    logic        cnt_clr;
    logic [15:0] stall_cnt;
    logic [15:0] bubble_cnt;

    logic        sat_up_ready;
    logic        sat_dn_valid;
    logic [31:0] sat_dn_data;
    logic [1:0]  sat_occupancy;
    logic [1:0]  sat_stall_cnt;
    logic [1:0]  sat_bubble_cnt;

    logic        s0_flush;
    logic        s0_up_valid;
    logic        s0_up_ready;
    logic [31:0] s0_up_data;
    logic        s0_dn_valid;
    logic        s0_dn_ready;
    logic [31:0] s0_dn_data;
    logic [1:0]  s0_occupancy;
    logic        s0_cnt_clr;
    logic [15:0] s0_stall_cnt;
    logic [15:0] s0_bubble_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .occupancy(occupancy), .cnt_clr(cnt_clr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .up_valid(up_valid), .up_ready(sat_up_ready), .up_data(up_data),
        .dn_valid(sat_dn_valid), .dn_ready(dn_ready), .dn_data(sat_dn_data),
        .occupancy(sat_occupancy), .cnt_clr(cnt_clr),
        .stall_cnt(sat_stall_cnt), .bubble_cnt(sat_bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(s0_flush),
        .up_valid(s0_up_valid), .up_ready(s0_up_ready), .up_data(s0_up_data),
        .dn_valid(s0_dn_valid), .dn_ready(s0_dn_ready), .dn_data(s0_dn_data),
        .occupancy(s0_occupancy), .cnt_clr(s0_cnt_clr),
        .stall_cnt(s0_stall_cnt), .bubble_cnt(s0_bubble_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
        up_valid = 1'b1; up_data = 32'hDEADBEEF; dn_ready = 1'b0;
        step(); step();
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL rst_dn_valid got %b want 0", dn_valid); end
        checks++; if (dn_data !== 32'h0) begin errors++; $display("FAIL rst_dn_data got %h want 0", dn_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
        checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL rst_up_ready got %b want 1", up_ready); end
        rst = 1'b0;
        step();
        checks++; if (dn_valid !== 1'b1 || dn_data !== 32'hDEADBEEF) begin errors++; $display("FAIL post_rst_load got %b/%h want 1/deadbeef", dn_valid, dn_data); end
        up_valid = 1'b0; dn_ready = 1'b1;
        step();
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin errors++; $display("FAIL post_rst_drain got %b/%h want 0/0", dn_valid, dn_data); end
    endtask

    task automatic test_streaming();
        dn_ready = 1'b1; up_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            up_data = i;
            step();
            checks++; if (dn_valid !== 1'b1 || dn_data !== 32'(i)) begin errors++; $display("FAIL stream_%0d got %b/%h want 1/%h", i, dn_valid, dn_data, i); end
            checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %b want 1", i, up_ready); end
        end
        up_valid = 1'b0;
        step();
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin errors++; $display("FAIL stream_end got %b/%h want 0/0", dn_valid, dn_data); end
    endtask

    task automatic test_backpressure();
        dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hA; cnt_clr = 1'b1;
        step();
        checks++; if (occupancy !== 2'd1 || dn_data !== 32'hA || up_ready !== 1'b1) begin errors++; $display("FAIL bp_load_a got occ=%0d data=%h rdy=%b want 1/a/1", occupancy, dn_data, up_ready); end
        cnt_clr = 1'b0; up_data = 32'hB;
        step();
        checks++; if (occupancy !== 2'd2 || up_ready !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b want 2/0", occupancy, up_ready); end
        checks++; if (dn_data !== 32'hA || stall_cnt !== 16'd1) begin errors++; $display("FAIL bp_hold got data=%h stall=%0d want a/1", dn_data, stall_cnt); end
        up_valid = 1'b0;
        step();
        checks++; if (occupancy !== 2'd2 || stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall2 got occ=%0d stall=%0d want 2/2", occupancy, stall_cnt); end
        dn_ready = 1'b1;
        step();
        checks++; if (dn_valid !== 1'b1 || dn_data !== 32'hB || occupancy !== 2'd1) begin errors++; $display("FAIL bp_drain_b got %b/%h occ=%0d want 1/b/1", dn_valid, dn_data, occupancy); end
        checks++; if (up_ready !== 1'b1 || stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_after got rdy=%b stall=%0d want 1/2", up_ready, stall_cnt); end
        step();
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got %b/%h occ=%0d want 0/0/0", dn_valid, dn_data, occupancy); end
    endtask

    task automatic test_bubble();
        dn_ready = 1'b1; up_valid = 1'b0; cnt_clr = 1'b1;
        step();
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL bubble_clr got %0d want 0", bubble_cnt); end
        cnt_clr = 1'b0;
        step(); step(); step();
        checks++; if (bubble_cnt !== 16'd3) begin errors++; $display("FAIL bubble_cnt got %0d want 3", bubble_cnt); end
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin errors++; $display("FAIL bubble_out got %b/%h want 0/0", dn_valid, dn_data); end
    endtask

    task automatic test_flush();
        dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'hA;
        step();
        up_data = 32'hB;
        step();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
        up_data = 32'hC; flush = 1'b1;
        step();
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || occupancy !== 2'd0) begin errors++; $display("FAIL flush_clear got %b/%h occ=%0d want 0/0/0", dn_valid, dn_data, occupancy); end
        checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", up_ready); end
        flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
        step();
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin errors++; $display("FAIL flush_no_c got %b/%h want 0/0", dn_valid, dn_data); end
    endtask

    task automatic test_back_to_back();
        dn_ready = 1'b1; up_valid = 1'b1; up_data = 32'h0000_00D1;
        step();
        up_data = 32'h0000_00D2;
        step();
        checks++; if (dn_data !== 32'hD2 || occupancy !== 2'd1 || up_ready !== 1'b1) begin errors++; $display("FAIL b2b got data=%h occ=%0d rdy=%b want d2/1/1", dn_data, occupancy, up_ready); end
        up_valid = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h55; cnt_clr = 1'b1;
        step();
        checks++; if (sat_stall_cnt !== 2'd0 || sat_dn_data !== 32'h55) begin errors++; $display("FAIL sat_start got stall=%0d data=%h want 0/55", sat_stall_cnt, sat_dn_data); end
        cnt_clr = 1'b0; up_valid = 1'b0;
        step(); step(); step();
        checks++; if (sat_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_reach got %0d want 3", sat_stall_cnt); end
        step(); step(); step();
        checks++; if (sat_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", sat_stall_cnt); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("FAIL wide_stall got %0d want 6", stall_cnt); end
        cnt_clr = 1'b1;
        step();
        checks++; if (sat_stall_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr got %0d want 0", sat_stall_cnt); end
        cnt_clr = 1'b0;
        step();
        checks++; if (sat_stall_cnt !== 2'd1) begin errors++; $display("FAIL sat_resume got %0d want 1", sat_stall_cnt); end
        dn_ready = 1'b1;
        step();
    endtask

    task automatic test_mid_reset();
        dn_ready = 1'b0; up_valid = 1'b1; up_data = 32'h77;
        step(); step();
        rst = 1'b1; dn_ready = 1'b1;
        step();
        checks++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || occupancy !== 2'd0) begin errors++; $display("FAIL mid_rst got %b/%h occ=%0d want 0/0/0", dn_valid, dn_data, occupancy); end
        checks++; if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
        rst = 1'b0; up_valid = 1'b0;
    endtask

    task automatic test_noskid();
        s0_dn_ready = 1'b0; s0_up_valid = 1'b1; s0_up_data = 32'h11;
        #1;
        checks++; if (s0_up_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_empty got %b want 1", s0_up_ready); end
        step();
        checks++; if (s0_dn_valid !== 1'b1 || s0_dn_data !== 32'h11 || s0_occupancy !== 2'd1) begin errors++; $display("FAIL s0_load got %b/%h occ=%0d want 1/11/1", s0_dn_valid, s0_dn_data, s0_occupancy); end
        checks++; if (s0_up_ready !== 1'b0) begin errors++; $display("FAIL s0_ready_full got %b want 0", s0_up_ready); end
        s0_up_data = 32'h22;
        step();
        checks++; if (s0_dn_data !== 32'h11 || s0_stall_cnt !== 16'd1) begin errors++; $display("FAIL s0_hold got data=%h stall=%0d want 11/1", s0_dn_data, s0_stall_cnt); end
        s0_dn_ready = 1'b1;
        #1;
        checks++; if (s0_up_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_comb got %b want 1", s0_up_ready); end
        step();
        checks++; if (s0_dn_valid !== 1'b1 || s0_dn_data !== 32'h22) begin errors++; $display("FAIL s0_pass got %b/%h want 1/22", s0_dn_valid, s0_dn_data); end
        s0_up_valid = 1'b0;
        step();
        checks++; if (s0_dn_valid !== 1'b0 || s0_dn_data !== 32'h0 || s0_occupancy !== 2'd0) begin errors++; $display("FAIL s0_empty got %b/%h occ=%0d want 0/0/0", s0_dn_valid, s0_dn_data, s0_occupancy); end
    endtask

    initial begin
        s0_flush = 1'b0; s0_cnt_clr = 1'b0;
        s0_up_valid = 1'b0; s0_up_data = 32'h0; s0_dn_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_noskid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
